reg_fwd_scoreboard: RTL and testbench

Parametrised operand-bypass and hazard unit for the rooth decode stage. Serves RD_PORTS register read ports, forwards from FWD_STAGES in-flight write sources plus a long-latency completion bus, and keeps a per-register pending scoreboard for multi-cycle ops (load, mul, div). When an operand is not yet available, it raises a stall and counts stall cycles.

---
 rtl/reg_fwd_scoreboard_pkg.sv | 17 +
 rtl/reg_fwd_scoreboard_fwd_port_sel.sv | 93 +++++++++
 rtl/reg_fwd_scoreboard.sv | 112 +++++++++++
 tb/tb_reg_fwd_scoreboard.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_fwd_scoreboard_pkg.sv
// Shared types and widths for the decode-stage operand bypass / hazard unit.
// REG_ADDR_WIDTH and CPU_WIDTH carry the same values as the core-wide
// defines, so the bypass block builds stand-alone.
package reg_fwd_scoreboard_pkg;

  localparam int REG_ADDR_WIDTH = 5;
  localparam int CPU_WIDTH      = 32;

  // Where a read port takes its operand from, highest priority first.
  typedef enum logic [1:0] {
    SRC_ZERO = 2'd0,  // architectural x0
    SRC_DONE = 2'd1,  // long-latency completion bus
    SRC_FWD  = 2'd2,  // one of the in-flight pipeline writers
    SRC_RF   = 2'd3   // register file read data
  } op_src_e;

endpackage

// File: rtl/reg_fwd_scoreboard_fwd_port_sel.sv
// One read port: picks the operand source by priority and flags a hazard
// when the operand belongs to a long-latency op that has not completed.
// Purely combinational.
module fwd_port_sel
  import reg_fwd_scoreboard_pkg::*;
#(
  parameter int FWD_STAGES = 2,
  parameter int AW         = REG_ADDR_WIDTH,
  parameter int DW         = CPU_WIDTH
) (
  input  logic                     rd_en_i,
  input  logic [AW-1:0]            rd_adder_i,
  input  logic [DW-1:0]            rf_rd_data_i,
  input  logic [FWD_STAGES-1:0]    fwd_wr_en_i,
  input  logic [FWD_STAGES*AW-1:0] fwd_wr_adder_i,
  input  logic [FWD_STAGES*DW-1:0] fwd_wr_data_i,
  input  logic                     lat_done_valid_i,
  input  logic [AW-1:0]            lat_done_adder_i,
  input  logic [DW-1:0]            lat_done_data_i,
  input  logic                     pend_i,
  output logic [DW-1:0]            rd_data_o,
  output logic [AW-1:0]            rd_adder_o,
  output logic                     hazard_o
);

  logic [FWD_STAGES-1:0] w_fwd_hit;
  logic                  w_addr_zero;
  logic                  w_done_hit;
  logic [DW-1:0]         w_fwd_data;
  op_src_e               w_src;

  assign w_addr_zero = (rd_adder_i == '0);
  assign w_done_hit  = lat_done_valid_i && (lat_done_adder_i == rd_adder_i);

  genvar gi;
  generate
    for (gi = 0; gi < FWD_STAGES; gi++) begin : g_hit
      assign w_fwd_hit[gi] = fwd_wr_en_i[gi] &&
                             (fwd_wr_adder_i[gi*AW +: AW] == rd_adder_i);
    end
  endgenerate

  // Youngest matching stage wins: scan oldest to youngest, last hit sticks.
  always_comb begin
    w_fwd_data = '0;
    for (int s = FWD_STAGES - 1; s >= 0; s--) begin
      if (w_fwd_hit[s]) begin
        w_fwd_data = fwd_wr_data_i[s*DW +: DW];
      end
    end
  end

  // Source priority: x0, completion bus, forwarding stages, register file.
  always_comb begin
    w_src = SRC_RF;
    if (w_addr_zero) begin
      w_src = SRC_ZERO;
    end else if (w_done_hit) begin
      w_src = SRC_DONE;
    end else if (|w_fwd_hit) begin
      w_src = SRC_FWD;
    end
  end

  // Operand mux; the address is only passed on when the RF value is used.
  always_comb begin
    rd_data_o  = '0;
    rd_adder_o = '0;
    case (w_src)
      SRC_ZERO: begin
        rd_data_o  = '0;
        rd_adder_o = '0;
      end
      SRC_DONE: begin
        rd_data_o  = lat_done_data_i;
        rd_adder_o = '0;
      end
      SRC_FWD: begin
        rd_data_o  = w_fwd_data;
        rd_adder_o = '0;
      end
      default: begin
        rd_data_o  = rf_rd_data_i;
        rd_adder_o = rd_adder_i;
      end
    endcase
  end

  // A pending register stalls even if an older stage forwards a stale value;
  // only the completion bus itself resolves it.
  assign hazard_o = rd_en_i && !w_addr_zero && pend_i && !w_done_hit;

endmodule

// File: rtl/reg_fwd_scoreboard.sv
// Operand bypass and hazard unit for the decode stage. Holds the per-register
// pending scoreboard for long-latency ops, arbitrates issue against it, and
// counts stalled cycles. Per-port source selection lives in fwd_port_sel.
module reg_fwd_scoreboard
  import reg_fwd_scoreboard_pkg::*;
#(
  parameter int RD_PORTS   = 2,
  parameter int FWD_STAGES = 2,
  parameter int AW         = REG_ADDR_WIDTH,
  parameter int DW         = CPU_WIDTH,
  parameter int CNT_W      = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [RD_PORTS-1:0]      rd_en_i,
  input  logic [RD_PORTS*AW-1:0]   rd_adder_i,
  input  logic [RD_PORTS*DW-1:0]   rf_rd_data_i,
  input  logic [FWD_STAGES-1:0]    fwd_wr_en_i,
  input  logic [FWD_STAGES*AW-1:0] fwd_wr_adder_i,
  input  logic [FWD_STAGES*DW-1:0] fwd_wr_data_i,
  input  logic                     lat_issue_valid_i,
  input  logic [AW-1:0]            lat_issue_adder_i,
  output logic                     lat_issue_ready_o,
  input  logic                     lat_done_valid_i,
  input  logic [AW-1:0]            lat_done_adder_i,
  input  logic [DW-1:0]            lat_done_data_i,
  output logic [RD_PORTS*DW-1:0]   rd_data_o,
  output logic [RD_PORTS*AW-1:0]   rd_adder_o,
  output logic                     stall_o,
  output logic [(2**AW)-1:0]       pend_o,
  output logic [CNT_W-1:0]         stall_cnt_o
);

  localparam int NREG = 2 ** AW;

  logic [NREG-1:0]     r_pend;
  logic [NREG-1:0]     w_pend_next;
  logic [CNT_W-1:0]    r_stall_cnt;
  logic [RD_PORTS-1:0] w_hazard;
  logic                w_done_on_issue;
  logic                w_issue_acc;

  // A done for the register being issued frees it in the same cycle, so a
  // back-to-back reissue is not a WAW conflict.
  assign w_done_on_issue   = lat_done_valid_i && (lat_done_adder_i == lat_issue_adder_i);
  assign lat_issue_ready_o = !((lat_issue_adder_i != '0) &&
                               r_pend[lat_issue_adder_i] && !w_done_on_issue);
  assign w_issue_acc       = lat_issue_valid_i && lat_issue_ready_o &&
                             (lat_issue_adder_i != '0);

  genvar gi;
  generate
    for (gi = 0; gi < RD_PORTS; gi++) begin : g_port
      fwd_port_sel #(
        .FWD_STAGES (FWD_STAGES),
        .AW         (AW),
        .DW         (DW)
      ) u_sel (
        .rd_en_i          (rd_en_i[gi]),
        .rd_adder_i       (rd_adder_i[gi*AW +: AW]),
        .rf_rd_data_i     (rf_rd_data_i[gi*DW +: DW]),
        .fwd_wr_en_i      (fwd_wr_en_i),
        .fwd_wr_adder_i   (fwd_wr_adder_i),
        .fwd_wr_data_i    (fwd_wr_data_i),
        .lat_done_valid_i (lat_done_valid_i),
        .lat_done_adder_i (lat_done_adder_i),
        .lat_done_data_i  (lat_done_data_i),
        .pend_i           (r_pend[rd_adder_i[gi*AW +: AW]]),
        .rd_data_o        (rd_data_o[gi*DW +: DW]),
        .rd_adder_o       (rd_adder_o[gi*AW +: AW]),
        .hazard_o         (w_hazard[gi])
      );
    end

    // Per-bit scoreboard next state: issue sets, done clears, issue wins a tie.
    // A done to a clear bit is naturally a no-op; x0 is never pending.
    for (gi = 0; gi < NREG; gi++) begin : g_pend
      if (gi == 0) begin : g_zero
        assign w_pend_next[gi] = 1'b0;
      end else begin : g_reg
        logic w_set;
        logic w_clr;
        assign w_set = w_issue_acc && (lat_issue_adder_i == AW'(gi));
        assign w_clr = lat_done_valid_i && (lat_done_adder_i == AW'(gi));
        assign w_pend_next[gi] = w_set || (r_pend[gi] && !w_clr);
      end
    end
  endgenerate

  assign stall_o     = |w_hazard;
  assign pend_o      = r_pend;
  assign stall_cnt_o = r_stall_cnt;

  // Scoreboard register; reset drops every outstanding op.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend <= '0;
    end else begin
      r_pend <= w_pend_next;
    end
  end

  // Stalled-cycle counter, sticks at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (stall_o && !(&r_stall_cnt)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_fwd_scoreboard.sv
// Bench for reg_fwd_scoreboard: 3 read ports, 4 forwarding stages and a
// narrow stall counter so saturation is reachable. Each cycle the reference
// model predicts all outputs into a queue; the entry is popped and compared
// once the DUT outputs have settled.
module tb_reg_fwd_scoreboard;

  localparam int RP = 3;
  localparam int FS = 4;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int CW = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [RP-1:0]     rd_en;
  logic [RP*AW-1:0]  rd_adder;
  logic [RP*DW-1:0]  rf_data;
  logic [FS-1:0]     fwd_en;
  logic [FS*AW-1:0]  fwd_adder;
  logic [FS*DW-1:0]  fwd_data;
  logic              iss_v;
  logic [AW-1:0]     iss_a;
  logic              iss_rdy;
  logic              done_v;
  logic [AW-1:0]     done_a;
  logic [DW-1:0]     done_d;
  logic [RP*DW-1:0]  rd_data;
  logic [RP*AW-1:0]  rd_adder_out;
  logic              stall;
  logic [31:0]       pend;
  logic [CW-1:0]     cnt;

  always #5 clk = ~clk;

  reg_fwd_scoreboard #(
    .RD_PORTS   (RP),
    .FWD_STAGES (FS),
    .AW         (AW),
    .DW         (DW),
    .CNT_W      (CW)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .rd_en_i           (rd_en),
    .rd_adder_i        (rd_adder),
    .rf_rd_data_i      (rf_data),
    .fwd_wr_en_i       (fwd_en),
    .fwd_wr_adder_i    (fwd_adder),
    .fwd_wr_data_i     (fwd_data),
    .lat_issue_valid_i (iss_v),
    .lat_issue_adder_i (iss_a),
    .lat_issue_ready_o (iss_rdy),
    .lat_done_valid_i  (done_v),
    .lat_done_adder_i  (done_a),
    .lat_done_data_i   (done_d),
    .rd_data_o         (rd_data),
    .rd_adder_o        (rd_adder_out),
    .stall_o           (stall),
    .pend_o            (pend),
    .stall_cnt_o       (cnt)
  );

  typedef struct packed {
    logic [RP*DW-1:0] data;
    logic [RP*AW-1:0] adder;
    logic             stall;
    logic             ready;
    logic [31:0]      pend;
    logic [CW-1:0]    cnt;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] m_pend;
  int          m_cnt;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference prediction from current inputs and the model scoreboard.
  function automatic exp_t predict();
    exp_t e;
    logic [AW-1:0] a;
    logic          found;
    e = '0;
    for (int p = 0; p < RP; p++) begin
      a = rd_adder[p*AW +: AW];
      if (a == 0) begin
        e.data[p*DW +: DW]  = '0;
        e.adder[p*AW +: AW] = '0;
      end else if (done_v && done_a == a) begin
        e.data[p*DW +: DW]  = done_d;
        e.adder[p*AW +: AW] = '0;
      end else begin
        found = 1'b0;
        for (int s = 0; s < FS; s++) begin
          if (!found && fwd_en[s] && fwd_adder[s*AW +: AW] == a) begin
            found = 1'b1;
            e.data[p*DW +: DW] = fwd_data[s*DW +: DW];
          end
        end
        if (found) begin
          e.adder[p*AW +: AW] = '0;
        end else begin
          e.data[p*DW +: DW]  = rf_data[p*DW +: DW];
          e.adder[p*AW +: AW] = a;
        end
      end
      if (rd_en[p] && a != 0 && m_pend[a] && !(done_v && done_a == a))
        e.stall = 1'b1;
    end
    e.ready = !(iss_a != 0 && m_pend[iss_a] && !(done_v && done_a == iss_a));
    e.pend  = m_pend;
    e.cnt   = CW'(m_cnt);
    return e;
  endfunction

  task automatic idle();
    rd_en    = '0;
    rd_adder = '0;
    rf_data  = {$urandom(), $urandom(), $urandom()};
    fwd_en   = '0;
    fwd_adder = '0;
    fwd_data = {$urandom(), $urandom(), $urandom(), $urandom()};
    iss_v    = 1'b0;
    iss_a    = '0;
    done_v   = 1'b0;
    done_a   = '0;
    done_d   = '0;
  endtask

  task automatic rd(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
    rd_en[p] = 1'b1;
    rd_adder[p*AW +: AW] = a;
    rf_data[p*DW +: DW]  = d;
  endtask

  task automatic fwd(input int s, input logic [AW-1:0] a, input logic [DW-1:0] d);
    fwd_en[s] = 1'b1;
    fwd_adder[s*AW +: AW] = a;
    fwd_data[s*DW +: DW]  = d;
  endtask

  // Inputs are set just after a rising edge; predict, compare, advance.
  task automatic step(input string tag, input bit verbose);
    exp_t e;
    exp_t o;
    #1;
    if (rst) begin
      m_pend = '0;
      m_cnt  = 0;
    end
    e = predict();
    sb_q.push_back(e);
    o = sb_q.pop_front();
    for (int p = 0; p < RP; p++) begin
      check_val({tag, "_data"}, 64'(rd_data[p*DW +: DW]), 64'(o.data[p*DW +: DW]));
      check_val({tag, "_addr"}, 64'(rd_adder_out[p*AW +: AW]), 64'(o.adder[p*AW +: AW]));
    end
    check_val({tag, "_stall"}, 64'(stall), 64'(o.stall));
    check_val({tag, "_ready"}, 64'(iss_rdy), 64'(o.ready));
    check_val({tag, "_pend"}, 64'(pend), 64'(o.pend));
    check_val({tag, "_cnt"}, 64'(cnt), 64'(o.cnt));
    if (verbose)
      $display("txn %s stall=%0b ready=%0b pend=%08h cnt=%0d", tag, stall, iss_rdy, pend, cnt);
    // Model of the clock edge that follows.
    for (int a = 1; a < 32; a++) begin
      if (iss_v && o.ready && iss_a == a)     m_pend[a] = 1'b1;
      else if (done_v && done_a == a)         m_pend[a] = 1'b0;
    end
    m_pend[0] = 1'b0;
    if (o.stall && m_cnt < CNT_MAX) m_cnt++;
    if (rst) begin
      m_pend = '0;
      m_cnt  = 0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    m_pend = '0;
    m_cnt  = 0;
    rst    = 1'b1;
    idle();
    @(posedge clk);
    #1;
    step("reset", 1'b1);
    check_val("reset_pend", 64'(pend), 64'h0);
    check_val("reset_ready", 64'(iss_rdy), 64'h1);
    rst = 1'b0;

    // x0 always reads as zero, even with a stage writing x0.
    idle();
    fwd(0, 5'd0, 32'hDEAD);
    rd(0, 5'd0, 32'h1234);
    rd(1, 5'd0, 32'h5678);
    rd_en[1] = 1'b1;
    #1;
    check_val("x0_data0", 64'(rd_data[31:0]), 64'h0);
    check_val("x0_data1", 64'(rd_data[63:32]), 64'h0);
    check_val("x0_stall", 64'(stall), 64'h0);
    step("x0", 1'b1);

    // Youngest stage has priority.
    idle();
    fwd(0, 5'd5, 32'h11);
    fwd(1, 5'd5, 32'h22);
    rd(0, 5'd5, 32'hAAAA);
    #1;
    check_val("fwd_young", 64'(rd_data[31:0]), 64'h11);
    check_val("fwd_addr", 64'(rd_adder_out[4:0]), 64'h0);
    step("fwd_both", 1'b1);
    idle();
    fwd(1, 5'd5, 32'h22);
    rd(0, 5'd5, 32'hAAAA);
    #1;
    check_val("fwd_old", 64'(rd_data[31:0]), 64'h22);
    step("fwd_s1", 1'b1);

    // Issue x7, stall three cycles, then resolve from the done bus.
    idle();
    iss_v = 1'b1;
    iss_a = 5'd7;
    step("issue_x7", 1'b1);
    for (int i = 0; i < 3; i++) begin
      idle();
      rd(0, 5'd7, 32'hBEEF);
      #1;
      check_val("x7_stall", 64'(stall), 64'h1);
      step("read_x7", 1'b1);
    end
    check_val("x7_cnt", 64'(cnt), 64'd3);
    idle();
    rd(0, 5'd7, 32'hBEEF);
    done_v = 1'b1;
    done_a = 5'd7;
    done_d = 32'h55;
    #1;
    check_val("done_data", 64'(rd_data[31:0]), 64'h55);
    check_val("done_stall", 64'(stall), 64'h0);
    step("done_x7", 1'b1);
    check_val("done_clear", 64'(pend[7]), 64'h0);

    // WAW: a second issue is refused; done+reissue keeps the bit.
    idle();
    iss_v = 1'b1;
    iss_a = 5'd7;
    step("issue_x7b", 1'b1);
    idle();
    iss_v = 1'b1;
    iss_a = 5'd7;
    #1;
    check_val("waw_ready", 64'(iss_rdy), 64'h0);
    step("waw_x7", 1'b1);
    check_val("waw_pend", 64'(pend), 64'h80);
    idle();
    iss_v  = 1'b1;
    iss_a  = 5'd7;
    done_v = 1'b1;
    done_a = 5'd7;
    done_d = 32'h66;
    #1;
    check_val("reiss_ready", 64'(iss_rdy), 64'h1);
    step("reissue_x7", 1'b1);
    check_val("reiss_pend", 64'(pend[7]), 64'h1);
    idle();
    done_v = 1'b1;
    done_a = 5'd7;
    step("done_x7b", 1'b1);

    // Saturate the stall counter.
    idle();
    iss_v = 1'b1;
    iss_a = 5'd12;
    step("issue_x12", 1'b1);
    for (int i = 0; i < 15; i++) begin
      idle();
      rd(2, 5'd12, 32'h0);
      step("sat", 1'b0);
    end
    check_val("sat_cnt", 64'(cnt), 64'(CNT_MAX));
    idle();
    done_v = 1'b1;
    done_a = 5'd12;
    step("done_x12", 1'b1);

    // Mid-operation reset with x3 and x9 pending.
    idle();
    iss_v = 1'b1;
    iss_a = 5'd3;
    step("issue_x3", 1'b1);
    idle();
    iss_v = 1'b1;
    iss_a = 5'd9;
    step("issue_x9", 1'b1);
    check_val("pre_rst_pend", 64'(pend), 64'h208);
    idle();
    rd(0, 5'd3, 32'h1);
    rd(1, 5'd9, 32'h2);
    rst = 1'b1;
    #1;
    check_val("rst_pend", 64'(pend), 64'h0);
    check_val("rst_stall", 64'(stall), 64'h0);
    step("rst_mid", 1'b1);
    rst = 1'b0;
    idle();
    done_v = 1'b1;
    done_a = 5'd3;
    step("late_done", 1'b1);
    check_val("late_pend", 64'(pend), 64'h0);

    // Random traffic against the model.
    for (int c = 0; c < 10000; c++) begin
      idle();
      for (int p = 0; p < RP; p++) begin
        rd_en[p] = 1'($urandom_range(0, 1));
        rd_adder[p*AW +: AW] = AW'($urandom_range(0, 7));
        rf_data[p*DW +: DW]  = $urandom();
      end
      for (int s = 0; s < FS; s++) begin
        fwd_en[s] = 1'($urandom_range(0, 1));
        fwd_adder[s*AW +: AW] = AW'($urandom_range(0, 7));
      end
      iss_v  = ($urandom_range(0, 2) == 0);
      iss_a  = AW'($urandom_range(0, 7));
      done_v = ($urandom_range(0, 2) == 0);
      done_a = AW'($urandom_range(0, 7));
      done_d = $urandom();
      step("rand", 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
